// File: rtl/img_pkg.sv
// Shared constants and FSM state encoding for the image RAM read/write masters.
package img_pkg;
    localparam int IMG_ADDR_W = 19;
    localparam int IMG_DATA_W = 8;
    localparam int IMG_W_DEF  = 512;
    localparam int IMG_H_DEF  = 512;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT,
        OUT,
        FIN
    } state_t;
endpackage

// File: rtl/img_addr_gen.sv
// Raster position tracker for the image reader: walks col/row by STEP and
// produces the RAM address with adds only, plus the final-pixel flag.
module img_addr_gen
    import img_pkg::*;
#(
    parameter int ADDR_W    = IMG_ADDR_W,
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int STEP      = 2,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(STEP * IMG_W);
    localparam logic [ADDR_W:0]   STEP_X  = (ADDR_W+1)'(STEP);
    localparam logic [ADDR_W:0]   W_X     = (ADDR_W+1)'(IMG_W);
    localparam logic [ADDR_W:0]   H_X     = (ADDR_W+1)'(IMG_H);

    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W:0]   col_step;
    logic [ADDR_W:0]   row_step;
    logic              col_wrap;

    // One extra bit so the end-of-row compare cannot wrap.
    assign col_step = {1'b0, col} + STEP_X;
    assign row_step = {1'b0, row} + STEP_X;
    assign col_wrap = (col_step >= W_X);
    assign last     = col_wrap && (row_step >= H_X);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            row_base <= BASE;
            addr     <= BASE;
        end else if (init) begin
            col      <= '0;
            row      <= '0;
            row_base <= BASE;
            addr     <= BASE;
        end else if (adv) begin
            if (!col_wrap) begin
                col  <= col_step[ADDR_W-1:0];
                addr <= row_base + col_step[ADDR_W-1:0];
            end else begin
                col      <= '0;
                row      <= row_step[ADDR_W-1:0];
                row_base <= row_base + ROW_INC;
                addr     <= row_base + ROW_INC;
            end
        end
    end
endmodule

// File: rtl/img_ram_reader.sv
// Read-side master for the image input RAM: one outstanding fetch at a time,
// optional STEP decimation, pixels streamed out on valid/ready.
//   state  | meaning
//   IDLE   | waiting for start
//   SETTLE | one cycle after an address change, stale ram_ready ignored
//   WAIT   | waiting for ram_ready, timeout counter running
//   OUT    | pixel presented until accepted
//   FIN    | done pulse, back to IDLE
module img_ram_reader
    import img_pkg::*;
#(
    parameter int ADDR_W    = IMG_ADDR_W,
    parameter int DATA_W    = IMG_DATA_W,
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int STEP      = 2,
    parameter int BASE_ADDR = 0,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    input  logic              ram_ready,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);
    localparam logic [7:0] TCNT_MAX = 8'(TIMEOUT);

    if ((longint'(BASE_ADDR) + longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W))
        || (STEP < 1) || (TIMEOUT > 255) || (TIMEOUT < 0)) begin : g_bad_cfg
        $error("img_ram_reader: image does not fit address space or bad STEP/TIMEOUT");
    end

    state_t     state, state_nxt;
    logic [7:0] tcnt;
    logic       gen_init;
    logic       gen_adv;
    logic       gen_last;

    img_addr_gen #(
        .ADDR_W    (ADDR_W),
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .STEP      (STEP),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .init (gen_init),
        .adv  (gen_adv),
        .addr (ram_addr),
        .last (gen_last)
    );

    always_comb begin
        state_nxt = state;
        gen_init  = 1'b0;
        gen_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    gen_init  = 1'b1;
                end
            end
            SETTLE: state_nxt = WAIT;
            WAIT: begin
                if (ram_ready)             state_nxt = OUT;
                else if (tcnt == TCNT_MAX) state_nxt = FIN;
            end
            OUT: begin
                if (pix_ready) begin
                    if (pix_last) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = SETTLE;
                        gen_adv   = 1'b1;
                    end
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done/busy are updated on the edge entering FIN so done is high while in FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            tcnt      <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        err  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                SETTLE: tcnt <= '0;
                WAIT: begin
                    if (ram_ready) begin
                        pix_data  <= ram_q;
                        pix_valid <= 1'b1;
                        pix_last  <= gen_last;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (tcnt == TCNT_MAX) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                OUT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                        if (pix_last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
